falu_cmp_unit: RTL and testbench

//  Registered IEEE-754 floating-point compare/min-max unit of the FALU.

---
 rtl/falu_cmp_unit.sv | 151 +++++++++++++++
 tb/tb_falu_cmp_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/falu_cmp_unit.sv
// falu_cmp_unit: registered IEEE-754 compare / min-max unit for the FALU.
// Handles FEQ, FLT, FLE, FMIN and FMAX on binary32 or binary64 operands.
// The result and NV flag appear one clock after the operands are accepted.
module falu_cmp_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [63:0] op1,
    input  logic [63:0] op2,
    input  logic        is_double,
    input  logic [2:0]  operation,
    output logic        out_valid,
    output logic [63:0] result,
    output logic        invalid
);

    typedef enum logic [2:0] {
        OP_FMIN = 3'b000,
        OP_FMAX = 3'b001,
        OP_FEQ  = 3'b010,
        OP_FLT  = 3'b011,
        OP_FLE  = 3'b100
    } cmp_op_e;

    localparam logic [63:0] CANON_NAN_DP = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] CANON_NAN_SP = 64'h0000_0000_7FC0_0000;

    // Per-operand fields, already reduced to the selected precision.
    // The magnitude holds {exponent, mantissa} right-aligned, so a plain
    // unsigned compare gives IEEE magnitude order, including subnormals
    // and infinities.
    logic        sign_a, sign_b;
    logic        exp_ones_a, exp_ones_b;
    logic        man_nz_a, man_nz_b;
    logic        man_msb_a, man_msb_b;
    logic [62:0] mag_a, mag_b;
    logic [63:0] val_a, val_b;

    // Derived classification and ordering terms.
    logic        nan_a, nan_b;
    logic        snan_a, snan_b;
    logic        any_nan, any_snan;
    logic        both_zero;
    logic        mag_lt, mag_gt, mag_eq;
    logic        total_lt;
    logic        ieee_lt;
    logic        ieee_eq;
    logic [63:0] canon_nan;

    // Next-cycle values captured by the output register.
    logic [63:0] result_next;
    logic        invalid_next;

    // Select the fields of each operand for the active precision; SP ignores the upper word.
    always_comb begin
        sign_a     = is_double ? op1[63]       : op1[31];
        sign_b     = is_double ? op2[63]       : op2[31];
        exp_ones_a = is_double ? (&op1[62:52]) : (&op1[30:23]);
        exp_ones_b = is_double ? (&op2[62:52]) : (&op2[30:23]);
        man_nz_a   = is_double ? (|op1[51:0])  : (|op1[22:0]);
        man_nz_b   = is_double ? (|op2[51:0])  : (|op2[22:0]);
        man_msb_a  = is_double ? op1[51]       : op1[22];
        man_msb_b  = is_double ? op2[51]       : op2[22];
        mag_a      = is_double ? op1[62:0]     : {32'b0, op1[30:0]};
        mag_b      = is_double ? op2[62:0]     : {32'b0, op2[30:0]};
        val_a      = is_double ? op1           : {32'b0, op1[31:0]};
        val_b      = is_double ? op2           : {32'b0, op2[31:0]};
        canon_nan  = is_double ? CANON_NAN_DP  : CANON_NAN_SP;
    end

    // Classify NaNs and build both orderings: IEEE (signed zeros equal) and total (-0 below +0).
    always_comb begin
        nan_a     = exp_ones_a & man_nz_a;
        nan_b     = exp_ones_b & man_nz_b;
        snan_a    = nan_a & ~man_msb_a;
        snan_b    = nan_b & ~man_msb_b;
        any_nan   = nan_a | nan_b;
        any_snan  = snan_a | snan_b;
        both_zero = (mag_a == 63'd0) && (mag_b == 63'd0);

        mag_lt = (mag_a < mag_b);
        mag_gt = (mag_a > mag_b);
        mag_eq = (mag_a == mag_b);

        // Differing signs: the negative operand is smaller. Same sign:
        // magnitude order, reversed for negatives.
        if (sign_a != sign_b) begin
            total_lt = sign_a;
        end else if (sign_a) begin
            total_lt = mag_gt;
        end else begin
            total_lt = mag_lt;
        end

        ieee_lt = total_lt & ~both_zero;
        ieee_eq = ((sign_a == sign_b) && mag_eq) || both_zero;
    end

    // Pick the result and NV flag for the requested operation; reserved codes give zeros.
    always_comb begin
        result_next  = 64'd0;
        invalid_next = 1'b0;

        case (cmp_op_e'(operation))
            OP_FEQ: begin
                result_next  = {63'd0, ieee_eq & ~any_nan};
                invalid_next = any_snan;
            end
            OP_FLT: begin
                result_next  = {63'd0, ieee_lt & ~any_nan};
                invalid_next = any_nan;
            end
            OP_FLE: begin
                result_next  = {63'd0, (ieee_lt | ieee_eq) & ~any_nan};
                invalid_next = any_nan;
            end
            OP_FMIN, OP_FMAX: begin
                invalid_next = any_snan;
                if (nan_a && nan_b) begin
                    result_next = canon_nan;
                end else if (nan_a) begin
                    result_next = val_b;
                end else if (nan_b) begin
                    result_next = val_a;
                end else if (operation == OP_FMIN) begin
                    result_next = total_lt ? val_a : val_b;
                end else begin
                    result_next = total_lt ? val_b : val_a;
                end
            end
            default: begin
                result_next  = 64'd0;
                invalid_next = 1'b0;
            end
        endcase
    end

    // Output register: reset wins over a simultaneous operation; idle cycles clear the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= 64'd0;
            invalid   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            result    <= in_valid ? result_next  : 64'd0;
            invalid   <= in_valid ? invalid_next : 1'b0;
        end
    end

endmodule

// File: tb/tb_falu_cmp_unit.sv
// tb_falu_cmp_unit: directed-vector bench for the FALU compare/min-max unit.
module tb_falu_cmp_unit;

    localparam logic [2:0] FMIN = 3'b000;
    localparam logic [2:0] FMAX = 3'b001;
    localparam logic [2:0] FEQ  = 3'b010;
    localparam logic [2:0] FLT  = 3'b011;
    localparam logic [2:0] FLE  = 3'b100;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [63:0] op1;
    logic [63:0] op2;
    logic        is_double;
    logic [2:0]  operation;
    logic        out_valid;
    logic [63:0] result;
    logic        invalid;

    int assertCount;
    int failCount;

    falu_cmp_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .op1       (op1),
        .op2       (op2),
        .is_double (is_double),
        .operation (operation),
        .out_valid (out_valid),
        .result    (result),
        .invalid   (invalid)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic v, input logic dp, input logic [2:0] op,
                                 input logic [63:0] a, input logic [63:0] b);
        in_valid  = v;
        is_double = dp;
        operation = op;
        op1       = a;
        op2       = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic expValid,
                               input logic [63:0] expResult, input logic expInvalid);
        assertCount++;
        assert (out_valid === expValid) else begin
            failCount++;
            $error("[TB] FAIL %s out_valid: observed %b expected %b", tag, out_valid, expValid);
        end
        assertCount++;
        assert (result === expResult) else begin
            failCount++;
            $error("[TB] FAIL %s result: observed %h expected %h", tag, result, expResult);
        end
        assertCount++;
        assert (invalid === expInvalid) else begin
            failCount++;
            $error("[TB] FAIL %s invalid: observed %b expected %b", tag, invalid, expInvalid);
        end
    endtask

    // One operation: drive, clock, check on the following cycle (steps chain back-to-back).
    task automatic step(input string tag, input logic dp, input logic [2:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] expResult, input logic expInvalid);
        applyStimulus(1'b1, dp, op, a, b);
        tick();
        checkOutput(tag, 1'b1, expResult, expInvalid);
    endtask

    // Directed sequence of vectors with hand-computed expectations.
    initial begin
        assertCount = 0;
        failCount   = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, FMIN, 64'd0, 64'd0);
        tick();
        tick();
        checkOutput("reset", 1'b0, 64'd0, 1'b0);
        rst = 1'b0;

        $display("[TB] directed vectors");
        step("dp_flt_m1_p1", 1'b1, FLT, 64'hBFF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'd1, 1'b0);
        step("sp_feq_zeros", 1'b0, FEQ, 64'hDEAD_BEEF_8000_0000, 64'h0000_0000_0000_0000, 64'd1, 1'b0);
        step("sp_fmin_zeros", 1'b0, FMIN, 64'hDEAD_BEEF_8000_0000, 64'h0000_0000_0000_0000,
             64'h0000_0000_8000_0000, 1'b0);
        step("sp_fmax_zeros", 1'b0, FMAX, 64'h0000_0000_8000_0000, 64'h1234_5678_0000_0000,
             64'h0000_0000_0000_0000, 1'b0);
        step("sp_feq_snan", 1'b0, FEQ, 64'h0000_0000_7F80_0001, 64'h0000_0000_3F80_0000, 64'd0, 1'b1);
        step("sp_feq_qnan", 1'b0, FEQ, 64'h0000_0000_7FC0_0000, 64'h0000_0000_3F80_0000, 64'd0, 1'b0);
        step("dp_fle_qnan", 1'b1, FLE, 64'h7FF8_0000_0000_0000, 64'h0, 64'd0, 1'b1);
        step("dp_fmax_snan", 1'b1, FMAX, 64'h7FF4_0000_0000_0000, 64'h4000_0000_0000_0000,
             64'h4000_0000_0000_0000, 1'b1);
        step("dp_fmax_2nan_s", 1'b1, FMAX, 64'h7FF8_0000_0000_0000, 64'h7FF0_0000_0000_0001,
             64'h7FF8_0000_0000_0000, 1'b1);
        step("dp_fmin_2nan_q", 1'b1, FMIN, 64'hFFF8_0000_0000_0000, 64'h7FF8_0000_0000_1234,
             64'h7FF8_0000_0000_0000, 1'b0);
        step("sp_fmin_2nan", 1'b0, FMIN, 64'h0000_0000_FFC0_0001, 64'h0000_0000_7F80_0001,
             64'h0000_0000_7FC0_0000, 1'b1);
        step("dp_flt_negs", 1'b1, FLT, 64'hC000_0000_0000_0000, 64'hBFF0_0000_0000_0000, 64'd1, 1'b0);
        step("dp_flt_negs_rev", 1'b1, FLT, 64'hBFF0_0000_0000_0000, 64'hC000_0000_0000_0000, 64'd0, 1'b0);
        step("dp_fle_equal", 1'b1, FLE, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'd1, 1'b0);
        step("dp_flt_equal", 1'b1, FLT, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'd0, 1'b0);
        step("dp_flt_pz_mz", 1'b1, FLT, 64'h0, 64'h8000_0000_0000_0000, 64'd0, 1'b0);
        step("dp_flt_mz_pz", 1'b1, FLT, 64'h8000_0000_0000_0000, 64'h0, 64'd0, 1'b0);
        step("dp_fle_pz_mz", 1'b1, FLE, 64'h0, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
        step("dp_fmin_pz_mz", 1'b1, FMIN, 64'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        step("sp_fmin_1_2", 1'b0, FMIN, 64'h0000_0000_3F80_0000, 64'h0000_0000_4000_0000,
             64'h0000_0000_3F80_0000, 1'b0);
        step("sp_fmax_1_2", 1'b0, FMAX, 64'h0000_0000_3F80_0000, 64'h0000_0000_4000_0000,
             64'h0000_0000_4000_0000, 1'b0);
        step("sp_fmax_qnan_neg", 1'b0, FMAX, 64'h0000_0000_7FC0_0000, 64'hFFFF_FFFF_BF80_0000,
             64'h0000_0000_BF80_0000, 1'b0);
        step("sp_flt_subnorm", 1'b0, FLT, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 64'd1, 1'b0);
        step("sp_flt_subnorm_rev", 1'b0, FLT, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001, 64'd0, 1'b0);
        step("dp_flt_pinf_ninf", 1'b1, FLT, 64'h7FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 64'd0, 1'b0);
        step("dp_fle_ninf_pinf", 1'b1, FLE, 64'hFFF0_0000_0000_0000, 64'h7FF0_0000_0000_0000, 64'd1, 1'b0);
        step("dp_feq_inf", 1'b1, FEQ, 64'h7FF0_0000_0000_0000, 64'h7FF0_0000_0000_0000, 64'd1, 1'b0);
        step("sp_feq_upper_ignored", 1'b0, FEQ, 64'hAAAA_AAAA_3F80_0000, 64'h5555_5555_3F80_0000, 64'd1, 1'b0);
        step("dp_feq_ne", 1'b1, FEQ, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0001, 64'd0, 1'b0);
        step("reserved_101", 1'b1, 3'b101, 64'h7FF4_0000_0000_0000, 64'h4000_0000_0000_0000, 64'd0, 1'b0);
        step("reserved_111", 1'b0, 3'b111, 64'h0000_0000_7F80_0001, 64'h0000_0000_3F80_0000, 64'd0, 1'b0);

        $display("[TB] idle cycle clears outputs");
        applyStimulus(1'b0, 1'b1, FMAX, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000);
        tick();
        checkOutput("idle", 1'b0, 64'd0, 1'b0);

        $display("[TB] reset colliding with in_valid");
        step("pre_reset_op", 1'b1, FMAX, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000,
             64'h4000_0000_0000_0000, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, FMAX, 64'h7FF4_0000_0000_0000, 64'h4000_0000_0000_0000);
        tick();
        checkOutput("reset_collision", 1'b0, 64'd0, 1'b0);
        rst = 1'b0;

        step("b2b_1", 1'b1, FLT, 64'hBFF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'd1, 1'b0);
        step("b2b_2", 1'b0, FMIN, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0000,
             64'h0000_0000_8000_0000, 1'b0);
        step("b2b_3", 1'b1, FLE, 64'h7FF8_0000_0000_0000, 64'h0, 64'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, FMIN, 64'd0, 64'd0);
        tick();
        checkOutput("final_idle", 1'b0, 64'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
